// File: rtl/key_itf_pkg.sv
// rtl/key_itf_pkg.sv - shared constants and state encoding for the front-panel key interface
// Contents: clock frequency, default timing windows, one-hot per-key FSM states,
//           debounce terminal-count helper.
package key_itf_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEF_KEY_NUM  = 4;
    localparam int DEF_DB_CYC   = CLK_HZ / 50;     // 20 ms
    localparam int DEF_LONG_CYC = CLK_HZ;          // 1.0 s
    localparam int DEF_REP_CYC  = CLK_HZ / 5;      // 0.2 s
    localparam int DEF_CNT_W    = 26;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_PRESS_DB  = 5'b00010,
        ST_HELD      = 5'b00100,
        ST_LONG_HELD = 5'b01000,
        ST_REL_DB    = 5'b10000
    } key_state_e;

    // The edge that enters a debounce state already counts as the first
    // sample of the window, so the window ends one count earlier than the
    // hold/repeat timers. This keeps the raw-edge-to-pulse latency at
    // DB_CYC+2 edges including the two synchroniser stages.
    function automatic int db_last(input int db_cyc);
        return (db_cyc >= 2) ? db_cyc - 2 : 0;
    endfunction

endpackage

// File: rtl/key_itf_if.sv
// rtl/key_itf_if.sv - key bus: raw active-low buttons in, debounced level and event pulses out
// Signals (all KEY_NUM wide): key_n (raw, low = pressed), key_level, key_press,
//                             key_release, key_long, key_repeat.
// Modports: master = panel/stimulus side, slave = key_itf side.
interface key_itf_if
    import key_itf_pkg::*;
#(
    parameter int KEY_NUM = DEF_KEY_NUM
);
    logic [KEY_NUM-1:0] key_n;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;
    logic [KEY_NUM-1:0] key_repeat;

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_long, key_repeat
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_long, key_repeat
    );
endinterface

// File: rtl/key_itf_db.sv
// rtl/key_itf_db.sv - single-key synchroniser, debounce / long-press / auto-repeat FSM
// Ports: sysclk, rst_n (async, active-low), key_n (raw, low = pressed),
//        key_level (debounced, 1 = pressed), key_press / key_release /
//        key_long / key_repeat (registered one-cycle pulses).
module key_db
    import key_itf_pkg::*;
#(
    parameter int DB_CYC   = DEF_DB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(db_last(DB_CYC));
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic       sync1;
    logic       sync2;
    logic       key_s;

    key_state_e       state;
    key_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             long_nxt;
    logic             repeat_nxt;

    // Synchroniser idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign key_s = ~sync2;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
            key_repeat  <= repeat_nxt;
        end
    end

    // Every terminal-count compare happens before the increment, so cnt
    // never wraps; every state change clears cnt.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (key_s) state_nxt = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (!key_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (!key_s) begin
                    state_nxt = ST_REL_DB;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = ST_LONG_HELD;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (!key_s) begin
                    state_nxt = ST_REL_DB;
                    cnt_nxt   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                end
            end
            ST_REL_DB: begin
                // A bounce back to pressed restarts the long-press timer
                // without reporting a second press.
                if (key_s) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/key_itf.sv
// rtl/key_itf.sv - front-panel key interface top: KEY_NUM independent key_db channels
// Ports: sysclk, rst_n (async, active-low), bus (key_itf_if.slave: key_n in;
//        key_level, key_press, key_release, key_long, key_repeat out).
module key_itf
    import key_itf_pkg::*;
#(
    parameter int KEY_NUM  = DEF_KEY_NUM,
    parameter int DB_CYC   = DEF_DB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        sysclk,
    input  logic        rst_n,
    key_itf_if.slave    bus
);

    logic [KEY_NUM-1:0] level_v;
    logic [KEY_NUM-1:0] press_v;
    logic [KEY_NUM-1:0] release_v;
    logic [KEY_NUM-1:0] long_v;
    logic [KEY_NUM-1:0] repeat_v;

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        key_db #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC),
            .CNT_W    (CNT_W)
        ) u_key_db (
            .sysclk      (sysclk),
            .rst_n       (rst_n),
            .key_n       (bus.key_n[g]),
            .key_level   (level_v[g]),
            .key_press   (press_v[g]),
            .key_release (release_v[g]),
            .key_long    (long_v[g]),
            .key_repeat  (repeat_v[g])
        );
    end

    assign bus.key_level   = level_v;
    assign bus.key_press   = press_v;
    assign bus.key_release = release_v;
    assign bus.key_long    = long_v;
    assign bus.key_repeat  = repeat_v;

endmodule

// File: tb/tb_key_itf.sv
// tb/tb_key_itf.sv - self-checking bench for key_itf
module tb_key_itf;
    import key_itf_pkg::*;

    localparam int KN   = 4;
    localparam int DB   = 4;
    localparam int LONG = 10;
    localparam int REP  = 3;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    key_itf_if #(.KEY_NUM(KN)) bus ();

    key_itf #(
        .KEY_NUM  (KN),
        .DB_CYC   (DB),
        .LONG_CYC (LONG),
        .REP_CYC  (REP),
        .CNT_W    (8)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    // Reference model: key_s is raw input delayed two edges; the debounced
    // level flips after DB consecutive opposite samples; while held, a timer
    // counts held cycles since the last (re)entry into the held phase.
    logic [KN-1:0] m_s1, m_s2;
    int  run1 [KN];
    int  run0 [KN];
    int  htim [KN];
    bit  lvl  [KN];
    bit  ldone[KN];
    logic [KN-1:0] e_level, e_press, e_release, e_long, e_repeat;

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1;
        e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        for (int k = 0; k < KN; k++) begin
            run1[k] = 0; run0[k] = 0; htim[k] = 0; lvl[k] = 0; ldone[k] = 0;
        end
    endtask

    task automatic model_step();
        logic [KN-1:0] s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = ~m_s2;
        m_s2 = m_s1;
        m_s1 = bus.key_n;
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        for (int k = 0; k < KN; k++) begin
            if (!lvl[k]) begin
                run1[k] = s[k] ? run1[k] + 1 : 0;
                if (run1[k] == DB) begin
                    e_press[k] = 1'b1;
                    lvl[k] = 1; htim[k] = 0; ldone[k] = 0; run1[k] = 0; run0[k] = 0;
                end
            end else if (!s[k]) begin
                run0[k]++;
                if (run0[k] == DB) begin
                    e_release[k] = 1'b1;
                    lvl[k] = 0; run0[k] = 0; run1[k] = 0;
                end
            end else if (run0[k] > 0) begin
                run0[k] = 0; htim[k] = 0; ldone[k] = 0;
            end else begin
                htim[k]++;
                if (!ldone[k] && htim[k] == LONG) begin
                    e_long[k] = 1'b1; ldone[k] = 1; htim[k] = 0;
                end else if (ldone[k] && htim[k] == REP) begin
                    e_repeat[k] = 1'b1; htim[k] = 0;
                end
            end
            e_level[k] = lvl[k];
        end
    endtask

    // Event recorder for directed scenarios (cycle numbers from clear_rec).
    int cyc;
    int f_press[KN], f_long[KN], f_rel[KN];
    int n_press[KN], n_long[KN], n_rep[KN], n_rel[KN], n_lvl[KN];

    task automatic clear_rec();
        cyc = 0;
        for (int k = 0; k < KN; k++) begin
            f_press[k] = 0; f_long[k] = 0; f_rel[k] = 0;
            n_press[k] = 0; n_long[k] = 0; n_rep[k] = 0; n_rel[k] = 0; n_lvl[k] = 0;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    int model_err_prints = 0;

    task automatic tick();
        @(posedge sysclk);
        model_step();
        #1;
        checks++;
        if ({bus.key_level, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat} !==
            {e_level, e_press, e_release, e_long, e_repeat}) begin
            errors++;
            if (model_err_prints < 20) begin
                model_err_prints++;
                $display("FAIL model t=%0t got lvl=%b prs=%b rel=%b lng=%b rep=%b exp lvl=%b prs=%b rel=%b lng=%b rep=%b",
                         $time, bus.key_level, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat,
                         e_level, e_press, e_release, e_long, e_repeat);
            end
        end
        cyc++;
        for (int k = 0; k < KN; k++) begin
            if (bus.key_press[k])   begin n_press[k]++; if (f_press[k] == 0) f_press[k] = cyc; end
            if (bus.key_long[k])    begin n_long[k]++;  if (f_long[k]  == 0) f_long[k]  = cyc; end
            if (bus.key_release[k]) begin n_rel[k]++;   if (f_rel[k]   == 0) f_rel[k]   = cyc; end
            if (bus.key_repeat[k])  n_rep[k]++;
            if (bus.key_level[k])   n_lvl[k]++;
        end
    endtask

    typedef struct {
        int key;
        int hold;
        int exp_press;
        int exp_long;
        int exp_rep;
        int exp_rel;
    } vec_t;

    vec_t vecs[8];
    int   cnt_dn[KN];

    initial begin
        vecs[0] = '{0,  8, 6,  0, 0, 14};
        vecs[1] = '{1,  2, 0,  0, 0,  0};
        vecs[2] = '{1,  3, 0,  0, 0,  0};
        vecs[3] = '{2, 30, 6, 16, 5, 36};
        vecs[4] = '{3,  4, 6,  0, 0, 10};
        vecs[5] = '{0, 14, 6, 16, 0, 20};
        vecs[6] = '{0, 16, 6, 16, 0, 22};
        vecs[7] = '{1, 17, 6, 16, 1, 23};

        bus.key_n = '1;
        model_reset();
        clear_rec();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs",
            int'({bus.key_level, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat}), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Table-driven single-key presses.
        foreach (vecs[i]) begin
            clear_rec();
            bus.key_n[vecs[i].key] = 1'b0;
            for (int c = 1; c <= vecs[i].hold + 10; c++) begin
                if (c == vecs[i].hold + 1) bus.key_n[vecs[i].key] = 1'b1;
                tick();
            end
            chk($sformatf("v%0d_press_cyc", i), f_press[vecs[i].key], vecs[i].exp_press);
            chk($sformatf("v%0d_long_cyc", i),  f_long[vecs[i].key],  vecs[i].exp_long);
            chk($sformatf("v%0d_rep_cnt", i),   n_rep[vecs[i].key],   vecs[i].exp_rep);
            chk($sformatf("v%0d_rel_cyc", i),   f_rel[vecs[i].key],   vecs[i].exp_rel);
            chk($sformatf("v%0d_level_cyc", i), n_lvl[vecs[i].key],   vecs[i].exp_rel - vecs[i].exp_press);
            repeat (3) tick();
        end

        // Bounce: low 3, high 1, low 10 -> one press timed from last fall.
        clear_rec();
        bus.key_n[1] = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            if (c == 4)  bus.key_n[1] = 1'b1;
            if (c == 5)  bus.key_n[1] = 1'b0;
            if (c == 15) bus.key_n[1] = 1'b1;
            tick();
        end
        chk("bounce_press_cnt", n_press[1], 1);
        chk("bounce_press_cyc", f_press[1], 10);
        chk("bounce_rel_cyc",   f_rel[1],   20);

        // Release bounce during REL_DB: no release, no new press, long restarts.
        clear_rec();
        bus.key_n[1] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 9)  bus.key_n[1] = 1'b1;
            if (c == 11) bus.key_n[1] = 1'b0;
            if (c == 30) bus.key_n[1] = 1'b1;
            tick();
        end
        chk("reldb_press_cnt", n_press[1], 1);
        chk("reldb_long_cyc",  f_long[1],  23);
        chk("reldb_rep_cnt",   n_rep[1],   2);
        chk("reldb_rel_cnt",   n_rel[1],   1);
        chk("reldb_rel_cyc",   f_rel[1],   35);

        // Simultaneous press of keys 0 and 3.
        clear_rec();
        bus.key_n = 4'b0110;
        for (int c = 1; c <= 30; c++) begin
            if (c == 9)  bus.key_n[0] = 1'b1;
            if (c == 21) bus.key_n[3] = 1'b1;
            tick();
            if (c == 6) chk("simul_press_vec", int'(bus.key_press), 9);
        end
        chk("simul_k0_rel",  f_rel[0],  14);
        chk("simul_k0_long", n_long[0], 0);
        chk("simul_k3_long", f_long[3], 16);
        chk("simul_k3_rel",  f_rel[3],  26);

        // Asynchronous reset while in LONG_HELD, key kept pressed.
        clear_rec();
        bus.key_n[2] = 1'b0;
        repeat (18) tick();
        chk("prerst_long_cyc", f_long[2], 16);
        chk("prerst_level", int'(bus.key_level[2]), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_outs",
            int'({bus.key_level, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat}), 0);
        clear_rec();
        repeat (2) tick();
        rst_n = 1'b1;
        clear_rec();
        repeat (10) tick();
        chk("postrst_press_cyc", f_press[2], 6);
        chk("postrst_no_rel",    n_rel[2],   0);
        bus.key_n[2] = 1'b1;
        repeat (12) tick();

        // Randomised run against the model.
        for (int k = 0; k < KN; k++) cnt_dn[k] = $urandom_range(1, 30);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < KN; k++) begin
                cnt_dn[k]--;
                if (cnt_dn[k] <= 0) begin
                    bus.key_n[k] = ~bus.key_n[k];
                    cnt_dn[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                                             : $urandom_range(1, 8);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
